instr_sequencer: RTL and testbench

- Multi-cycle control unit that sequences the instruction decoder (interpreter) and the execute datapath.
- Fetches a 16-bit instruction from instruction memory over a req/valid handshake and holds it in an instruction register (IR) that drives the decoder.
- Evaluates the decoded 2-bit condition against Z/N flags, then drives register-file read/write addresses, ALU opcode and writeback.
- Sits between instruction memory, the interpreter, the register file and the ALU.

---
 rtl/instr_sequencer.sv | 155 +++++++++++++++
 tb/tb_instr_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Multi-cycle control unit: fetches into IR, evaluates the decoded condition
// against stored Z/N, then drives register-file addresses, ALU op and writeback.
module instr_sequencer #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_valid,
  input  logic [15:0]      imem_data,
  output logic [15:0]      inst,
  input  logic [1:0]       dec_cond,
  input  logic [3:0]       dec_op,
  input  logic [2:0]       dec_dest,
  input  logic [2:0]       dec_src1,
  input  logic [2:0]       dec_src2,
  input  logic [6:0]       dec_shift,
  input  logic             alu_z,
  input  logic             alu_n,
  output logic [2:0]       rf_raddr1,
  output logic [2:0]       rf_raddr2,
  output logic [2:0]       rf_waddr,
  output logic             rf_we,
  output logic [3:0]       alu_op,
  output logic [PC_W-1:0]  pc,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT
  } state_t;

  localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [PC_W-1:0]  pc_q, pc_nxt;
  logic [15:0]      ir_q, ir_nxt;
  logic             z_q, n_q, z_nxt, n_nxt;
  logic [CNT_W-1:0] ret_q, ret_nxt, ret_inc;
  logic             cond_pass;
  logic [PC_W+6:0]  shift_ext;

  // Zero-extend then truncate so the branch target works for any PC_W.
  assign shift_ext = {{PC_W{1'b0}}, dec_shift};
  assign ret_inc   = (&ret_q) ? ret_q : ret_q + CNT_ONE;

  always_comb begin
    cond_pass = 1'b1;
    case (dec_cond)
      2'd0: cond_pass = 1'b1;
      2'd1: cond_pass = z_q;
      2'd2: cond_pass = !z_q;
      2'd3: cond_pass = n_q;
      default: cond_pass = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_FETCH;
      pc_q  <= '0;
      ir_q  <= '0;
      z_q   <= 1'b0;
      n_q   <= 1'b0;
      ret_q <= '0;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
      ir_q  <= ir_nxt;
      z_q   <= z_nxt;
      n_q   <= n_nxt;
      ret_q <= ret_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    ir_nxt    = ir_q;
    z_nxt     = z_q;
    n_nxt     = n_q;
    ret_nxt   = ret_q;
    imem_req  = 1'b0;
    rf_raddr1 = '0;
    rf_raddr2 = '0;
    rf_waddr  = '0;
    rf_we     = 1'b0;
    alu_op    = '0;
    case (state)
      S_FETCH: begin
        imem_req = rst_n;
        if (imem_valid) begin
          ir_nxt    = imem_data;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!cond_pass) begin
          pc_nxt    = pc_q + PC_ONE;
          ret_nxt   = ret_inc;
          state_nxt = S_FETCH;
        end else if (dec_op == 4'hF) begin
          state_nxt = S_HALT;
        end else begin
          state_nxt = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        rf_raddr1 = dec_src1;
        rf_raddr2 = dec_src2;
        alu_op    = dec_op;
        state_nxt = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        rf_raddr1 = dec_src1;
        rf_raddr2 = dec_src2;
        alu_op    = dec_op;
        ret_nxt   = ret_inc;
        state_nxt = S_FETCH;
        pc_nxt    = pc_q + PC_ONE;
        if (dec_op < 4'd12) begin
          rf_we    = rst_n;
          rf_waddr = dec_dest;
          z_nxt    = alu_z;
          n_nxt    = alu_n;
        end else if (dec_op == 4'd12) begin
          z_nxt = alu_z;
          n_nxt = alu_n;
        end else if (dec_op == 4'd13) begin
          pc_nxt = shift_ext[PC_W-1:0];
        end
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase
    // Everything the sequencer drives reads as zero while reset is held.
    if (!rst_n) begin
      rf_raddr1 = '0;
      rf_raddr2 = '0;
      rf_waddr  = '0;
      alu_op    = '0;
    end
  end

  assign imem_addr = rst_n ? pc_q : '0;
  assign pc        = rst_n ? pc_q : '0;
  assign inst      = rst_n ? ir_q : '0;
  assign retired   = rst_n ? ret_q : '0;
  assign halted    = rst_n && (state == S_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer; the bench plays instruction memory,
// decoder ({cond,op,dest,src1,src2,-}, shift = inst[6:0]) and ALU flags.
module tb_instr_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_valid;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data, inst;
  logic [1:0]  dec_cond;
  logic [3:0]  dec_op, alu_op;
  logic [2:0]  dec_dest, dec_src1, dec_src2;
  logic [6:0]  dec_shift;
  logic        alu_z, alu_n;
  logic [2:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic        rf_we, halted;
  logic [7:0]  pc;
  logic [15:0] retired;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign dec_cond  = inst[15:14];
  assign dec_op    = inst[13:10];
  assign dec_dest  = inst[9:7];
  assign dec_src1  = inst[6:4];
  assign dec_src2  = inst[3:1];
  assign dec_shift = inst[6:0];

  instr_sequencer #(.PC_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data), .inst(inst),
    .dec_cond(dec_cond), .dec_op(dec_op), .dec_dest(dec_dest),
    .dec_src1(dec_src1), .dec_src2(dec_src2), .dec_shift(dec_shift),
    .alu_z(alu_z), .alu_n(alu_n),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_waddr(rf_waddr),
    .rf_we(rf_we), .alu_op(alu_op), .pc(pc), .halted(halted), .retired(retired)
  );

  function automatic logic [15:0] mk(input logic [1:0] c, input logic [3:0] op,
                                     input logic [2:0] d, input logic [2:0] s1,
                                     input logic [2:0] s2);
    return {c, op, d, s1, s2, 1'b0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; imem_valid = 1'b0; imem_data = '0; alu_z = 1'b0; alu_n = 1'b0;
    step(); step();
    chk("rst_req", imem_req, 0);
    chk("rst_pc", pc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_retired", retired, 0);
    chk("rst_we", rf_we, 0);

    // ALU op 3, dest 5, src 1/2, memory always ready
    imem_valid = 1'b1;
    imem_data  = mk(2'd0, 4'd3, 3'd5, 3'd1, 3'd2);
    rst_n = 1'b1;
    #1;
    chk("c1_req", imem_req, 1);
    chk("c1_addr", imem_addr, 0);
    step();
    chk("c2_inst", inst, mk(2'd0, 4'd3, 3'd5, 3'd1, 3'd2));
    chk("c2_we", rf_we, 0);
    step();
    chk("c3_ra1", rf_raddr1, 1);
    chk("c3_ra2", rf_raddr2, 2);
    chk("c3_op", alu_op, 3);
    chk("c3_we", rf_we, 0);
    step();
    chk("c4_we", rf_we, 1);
    chk("c4_waddr", rf_waddr, 5);
    step();
    chk("alu_we_end", rf_we, 0);
    chk("alu_pc", pc, 1);
    chk("alu_ret", retired, 1);

    // memory stall
    imem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_req", imem_req, 1);
      chk("stall_addr", imem_addr, 1);
      chk("stall_we", rf_we, 0);
    end

    // CMP sets Z, then cond=!Z op5 is skipped
    imem_valid = 1'b1;
    imem_data  = mk(2'd0, 4'd12, 3'd4, 3'd1, 3'd1);
    alu_z = 1'b1;
    step(); step(); step();
    chk("cmp_we", rf_we, 0);
    step();
    chk("cmp_pc", pc, 2);
    chk("cmp_ret", retired, 2);
    alu_z = 1'b0;
    imem_data = mk(2'd2, 4'd5, 3'd3, 3'd1, 3'd2);
    step();
    chk("skip_we", rf_we, 0);
    step();
    chk("skip_req", imem_req, 1);
    chk("skip_pc", pc, 3);
    chk("skip_ret", retired, 3);

    // BR to 0x20 from pc 3
    imem_data = {2'd0, 4'd13, 3'd0, 7'h20};
    step(); step(); step();
    chk("br_we", rf_we, 0);
    step();
    chk("br_addr", imem_addr, 8'h20);
    chk("br_ret", retired, 4);

    // NOP cond=Z: Z set by CMP must survive the BR
    imem_data = mk(2'd1, 4'd14, 3'd0, 3'd0, 3'd0);
    step(); step(); step();
    chk("nop_we", rf_we, 0);
    step();
    chk("nop_pc", pc, 8'h21);
    chk("nop_ret", retired, 5);

    // skip forward (cond=N, N=0) to pc 0xFF
    imem_data = mk(2'd3, 4'd0, 3'd1, 3'd0, 3'd0);
    for (int i = 0; i < 222; i++) begin
      step(); step();
    end
    chk("walk_pc", pc, 8'hFF);
    chk("walk_ret", retired, 227);
    imem_data = mk(2'd0, 4'd14, 3'd0, 3'd0, 3'd0);
    step(); step(); step(); step();
    chk("wrap_addr", imem_addr, 8'h00);
    chk("wrap_ret", retired, 228);

    // HALT
    imem_data = mk(2'd0, 4'hF, 3'd0, 3'd0, 3'd0);
    step(); step();
    chk("halt_c3", halted, 1);
    chk("halt_req", imem_req, 0);
    chk("halt_ret", retired, 228);
    step(); step();
    chk("halt_hold", halted, 1);
    chk("halt_req2", imem_req, 0);
    chk("halt_pc", pc, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("unhalt", halted, 0);
    chk("unhalt_req", imem_req, 1);
    chk("unhalt_ret", retired, 0);

    // advance to pc 1 so the next reset has something to clear
    imem_data = mk(2'd0, 4'd14, 3'd0, 3'd0, 3'd0);
    step(); step(); step(); step();
    chk("pre_pc", pc, 1);
    imem_valid = 1'b0;
    step();

    // reset coinciding with imem_valid in FETCH
    rst_n = 1'b0;
    imem_valid = 1'b1;
    imem_data = mk(2'd0, 4'd3, 3'd5, 3'd1, 3'd2);
    step();
    rst_n = 1'b1;
    imem_valid = 1'b0;
    #1;
    chk("rv_inst", inst, 0);
    chk("rv_pc", pc, 0);
    chk("rv_ret", retired, 0);
    chk("rv_req", imem_req, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rv_we", rf_we, 0);
      chk("rv_inst_hold", inst, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
